ddr_port_arbiter: RTL
=====================

// Module: ddr_port_arbiter
// PURPOSE
//  Shares the single DDR controller request port (ADDRESS_REQ/WE/DO_ACT/COMMAND_LATCHED) among NPORTS clients.
//  Round-robin grant; holds one request on the controller until COMMAND_LATCHED; tracks read return latency
//  and routes DATA_R back to the issuing client. Sits between client masters and the enter_state/outputs pair.
// PARAMETERS
//  NPORTS        4    number of client ports (2..8)
//  PID_W         2    port-id width, clog2(NPORTS)
//  RD_LAT        3    cycles from COMMAND_LATCHED edge until DATA_R valid
//  MAX_HIT_STREAK 4   max consecutive page-hit grants (PAGE_HIT_PRIO_EN only)
// PORTS
//  CLK            in   1           system clock
//  RST            in   1           synchronous, active-low reset
//  REQ            in   NPORTS      client i requests; held high until ACK[i]
//  ADDR           in   NPORTS*27   client addresses, port i at [27*i+:27]
//  WE_IN          in   NPORTS      1=write, 0=read
//  WDATA          in   NPORTS*32   client write data
//  ACK            out  NPORTS      combinational: COMMAND_LATCHED & DO_ACT & (grant==i)
//  RVALID         out  NPORTS      registered one-cycle read-data strobe
//  RDATA          out  32          registered read data, valid with RVALID
//  ADDRESS_REQ    out  27          to controller
//  WE             out  1           to controller
//  DATA_W         out  32          to controller
//  DO_ACT         out  1           to controller
//  COMMAND_LATCHED in  1           from controller
//  DATA_R         in   32          from controller read path
// BEHAVIOUR
//  Reset: DO_ACT=0, ADDRESS_REQ=0, WE=0, DATA_W=0, RVALID=0, RDATA=0, rr pointer=NPORTS-1, grant=0,
//   read pipeline cleared (in-flight reads dropped, no RVALID after reset).
//  FSM IDLE/ISSUE. IDLE: if |REQ, pick first requester after rr pointer (wrap at NPORTS), register its
//   ADDR/WE_IN/WDATA to outputs, DO_ACT<=1, grant<=pick, rr<=pick, ->ISSUE. Else stay, DO_ACT=0.
//  ISSUE: outputs held stable while !COMMAND_LATCHED (refresh/precharge stalls tolerated, no timeout).
//   On COMMAND_LATCHED: ACK[grant]=1 this cycle; granted port excluded from this cycle's pick (stale REQ).
//   If another requester pending: load it same edge, stay ISSUE (back-to-back). Else DO_ACT<=0, ->IDLE.
//  Read return: shift pipeline depth RD_LAT+1 of {valid,pid}; stage0 <= {COMMAND_LATCHED&~WE, grant}.
//   When stage RD_LAT valid: RDATA<=DATA_R, RVALID[pid]<=1 (visible cycle RD_LAT+1 after latch).
//   Overlapping reads from distinct ports return in issue order; writes never produce RVALID.
//  Single requester repeated: granted every other cycle at most (ACK cycle excludes it).
//  REQ dropped by a client before ACK: illegal; arbiter keeps issuing latched request.
//  Addresses: row=[26:15], bank=[14:13], column=[12:0]; page key = ADDR[26:13].
// CONFIGURATION
//  PAGE_HIT_PRIO_EN defined: requester whose page key equals last issued key wins over round-robin
//   (lowest index among hits); hit-streak counter increments per hit grant, resets on miss grant;
//   at MAX_HIT_STREAK, hits ignored for one pick (pure round-robin). rr pointer updated on every grant.
//  Undefined: pure round-robin; no page-key or streak registers synthesized.
// STRUCTURE
//  Shared package/header ddr_defs: command codes NOOP/ACTV/READ/WRTE/PRCH/ARSR, ADDR_W=27, DATA_W=32,
//   ROW/BANK/COL bit ranges.
//  Sub-module ddr_rr_pick: combinational round-robin picker (req mask, pointer -> one-hot + index, any).
// TESTING
//  1 Port1 read A=0x0012345, CL 3 cycles later -> ACK[1] 1 cycle, RVALID[1]=1 with RDATA=DATA_R at latch+4.
//  2 REQ=4'b1111 held, CL every 2nd cycle -> grants 0,1,2,3,0 in order; each ACK exactly once per grant.
//  3 Port2 write 0xDEADBEEF, CL held low 12 cycles -> ADDRESS_REQ/DATA_W/WE/DO_ACT stable; ACK[2] on CL only.
//  4 Back-to-back reads ports 0 then 3 latched 2 cycles apart -> RVALID[0] then RVALID[3], 2 cycles apart.
//  5 RST low while read in flight -> DO_ACT=0, no RVALID for 8 cycles after release, rr restarts at port 0.
//  6 PAGE_HIT_PRIO_EN, ports 0,2 same page, port1 other, all REQ -> 4 hit grants then port1 granted.

Source files
------------

// File: rtl/ddr_defs_pkg.sv
// rtl/ddr_defs_pkg.sv - shared DDR command codes, widths and address field ranges
package ddr_defs;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;

    localparam int ROW_HI  = 26;
    localparam int ROW_LO  = 15;
    localparam int BANK_HI = 14;
    localparam int BANK_LO = 13;
    localparam int COL_HI  = 12;
    localparam int COL_LO  = 0;

    // Page key is row and bank together: two accesses with equal keys hit an open page
    localparam int KEY_W   = ROW_HI - BANK_LO + 1;

    typedef enum logic [2:0] {
        CMD_NOOP = 3'd0,
        CMD_ACTV = 3'd1,
        CMD_READ = 3'd2,
        CMD_WRTE = 3'd3,
        CMD_PRCH = 3'd4,
        CMD_ARSR = 3'd5
    } ddr_cmd_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    function automatic logic [KEY_W-1:0] page_key(input logic [ADDR_W-1:0] addr);
        return addr[ROW_HI:BANK_LO];
    endfunction

endpackage

// File: rtl/ddr_rr_pick.sv
// rtl/ddr_rr_pick.sv - combinational round-robin picker, first requester after the pointer
module ddr_rr_pick #(
    parameter int NPORTS = 4,
    parameter int PID_W  = 2
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PID_W-1:0]  ptr,
    output logic [NPORTS-1:0] onehot,
    output logic [PID_W-1:0]  idx,
    output logic              any
);

    int unsigned pos;

    // Scan ptr+1, ptr+2, ... wrapping at NPORTS; the pointer itself is visited last
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            pos = (int'(ptr) + k) % NPORTS;
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos[PID_W-1:0];
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - round-robin DDR request port arbiter with read return routing; option PAGE_HIT_PRIO_EN
module ddr_port_arbiter #(
    parameter int NPORTS         = 4,
    parameter int PID_W          = 2,
    parameter int RD_LAT         = 3,
    parameter int MAX_HIT_STREAK = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NPORTS-1:0]                  REQ,
    input  logic [NPORTS*ddr_defs::ADDR_W-1:0] ADDR,
    input  logic [NPORTS-1:0]                  WE_IN,
    input  logic [NPORTS*ddr_defs::DATA_W-1:0] WDATA,
    output logic [NPORTS-1:0]                  ACK,
    output logic [NPORTS-1:0]                  RVALID,
    output logic [ddr_defs::DATA_W-1:0]        RDATA,
    output logic [ddr_defs::ADDR_W-1:0]        ADDRESS_REQ,
    output logic                               WE,
    output logic [ddr_defs::DATA_W-1:0]        DATA_W,
    output logic                               DO_ACT,
    input  logic                               COMMAND_LATCHED,
    input  logic [ddr_defs::DATA_W-1:0]        DATA_R
);

    import ddr_defs::*;

    arb_state_e                 state;
    arb_state_e                 state_nxt;
    logic [PID_W-1:0]           grant;
    logic [PID_W-1:0]           rr_ptr;
    logic [NPORTS-1:0]          grant_oh;
    logic                       latched;
    logic [NPORTS-1:0]          pick_req;
    logic [NPORTS-1:0]          rr_oh;
    logic [PID_W-1:0]           rr_idx;
    logic                       pick_any;
    logic [PID_W-1:0]           sel_idx;
    logic                       load;
    logic [ddr_defs::ADDR_W-1:0] sel_addr;

    logic [RD_LAT-1:0]          pipe_vld;
    logic [PID_W-1:0]           pipe_pid [RD_LAT];

    assign DO_ACT   = (state == ARB_ISSUE);
    assign grant_oh = {{(NPORTS-1){1'b0}}, 1'b1} << grant;
    assign latched  = COMMAND_LATCHED & DO_ACT;
    assign ACK      = latched ? grant_oh : '0;

    // The port being acknowledged still shows REQ this cycle, so it may not win the same edge
    assign pick_req = REQ & ~(latched ? grant_oh : '0);

    ddr_rr_pick #(
        .NPORTS (NPORTS),
        .PID_W  (PID_W)
    ) u_rr_pick (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .onehot (rr_oh),
        .idx    (rr_idx),
        .any    (pick_any)
    );

    assign sel_addr = ADDR[int'(sel_idx)*ddr_defs::ADDR_W +: ddr_defs::ADDR_W];

`ifdef PAGE_HIT_PRIO_EN
    localparam int STREAK_W = $clog2(MAX_HIT_STREAK + 1);

    logic [KEY_W-1:0]    last_key;
    logic                key_vld;
    logic [STREAK_W-1:0] hit_streak;
    logic [PID_W-1:0]    hit_idx;
    logic                hit_any;
    logic                use_hit;

    // Lowest-index requester on the last issued page wins unless the hit streak is exhausted
    always_comb begin
        hit_idx = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!hit_any && pick_req[i] && key_vld &&
                (page_key(ADDR[i*ddr_defs::ADDR_W +: ddr_defs::ADDR_W]) == last_key)) begin
                hit_any = 1'b1;
                hit_idx = PID_W'(i);
            end
        end
        use_hit = hit_any && (int'(hit_streak) < MAX_HIT_STREAK);
        sel_idx = use_hit ? hit_idx : rr_idx;
    end

    // Remember the issued page and count consecutive priority hits
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_key   <= '0;
            key_vld    <= 1'b0;
            hit_streak <= '0;
        end else if (load) begin
            last_key   <= page_key(sel_addr);
            key_vld    <= 1'b1;
            hit_streak <= use_hit ? hit_streak + 1'b1 : '0;
        end
    end
`else
    assign sel_idx = rr_idx;
`endif

    // Next-state: load a new request from idle, or back-to-back on the latch edge
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    load      = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (latched) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State, grant and controller-facing request registers; held while the controller stalls
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            rr_ptr      <= PID_W'(NPORTS - 1);
            ADDRESS_REQ <= '0;
            WE          <= 1'b0;
            DATA_W      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                grant       <= sel_idx;
                rr_ptr      <= sel_idx;
                ADDRESS_REQ <= sel_addr;
                WE          <= WE_IN[sel_idx];
                DATA_W      <= WDATA[int'(sel_idx)*ddr_defs::DATA_W +: ddr_defs::DATA_W];
            end
        end
    end

    // Read return pipeline: the output register is the final stage, sampling DATA_R RD_LAT cycles after the latch
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pipe_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_pid[s] <= '0;
            end
            RVALID <= '0;
            RDATA  <= '0;
        end else begin
            pipe_vld[0] <= latched & ~WE;
            pipe_pid[0] <= grant;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_pid[s] <= pipe_pid[s-1];
            end
            RVALID <= pipe_vld[RD_LAT-1] ? ({{(NPORTS-1){1'b0}}, 1'b1} << pipe_pid[RD_LAT-1]) : '0;
            if (pipe_vld[RD_LAT-1]) begin
                RDATA <= DATA_R;
            end
        end
    end

endmodule
